// File: rtl/itlb_stage.sv
// itlb_stage: translates the PC generator's fetch packet through a small fully-associative
// ITLB, walks the shared page-table walker on a miss, and forwards a registered packet to the
// I-cache stage. Bare mode (satp off or M-mode) passes the virtual PC through untranslated.
module itlb_stage #(
    parameter int unsigned ENTRIES = 8
) (
    input  logic        core_clock_i,
    input  logic        core_reset_n_i,
    input  logic        core_flush_i,
    input  logic        sfence_i,
    input  logic        satp_mode_i,
    input  logic [1:0]  priv_i,
    input  logic        pcgen_valid_i,
    input  logic [29:0] pcgen_pc_i,
    input  logic [1:0]  pcgen_btype_i,
    input  logic [1:0]  pcgen_bm_pred_i,
    input  logic [29:0] pcgen_target_i,
    input  logic        pcgen_index_i,
    input  logic        pcgen_hit_i,
    input  logic        pcgen_way_i,
    output logic        pcgen_busy_o,
    output logic        ptw_req_valid_o,
    input  logic        ptw_req_ready_i,
    output logic [19:0] ptw_req_vpn_o,
    input  logic        ptw_resp_valid_i,
    input  logic [19:0] ptw_resp_ppn_i,
    input  logic        ptw_resp_x_i,
    input  logic        ptw_resp_u_i,
    input  logic        ptw_resp_fault_i,
    input  logic        ic_busy_i,
    output logic        ic_valid_o,
    output logic [29:0] ic_vpc_o,
    output logic [29:0] ic_ppc_o,
    output logic        ic_fault_o,
    output logic [1:0]  ic_btype_o,
    output logic [1:0]  ic_bm_pred_o,
    output logic [29:0] ic_target_o,
    output logic        ic_index_o,
    output logic        ic_hit_o,
    output logic        ic_way_o
);

    localparam int unsigned IdxW = $clog2(ENTRIES);

    typedef enum logic [1:0] {StRun, StWalkReq, StWalkWait, StDrain} state_e;

    state_e state_q, state_d;

    logic [ENTRIES-1:0] ent_valid_q, ent_valid_d;
    logic [ENTRIES-1:0] ent_x_q, ent_x_d;
    logic [ENTRIES-1:0] ent_u_q, ent_u_d;
    logic [19:0]        ent_vpn_q [ENTRIES];
    logic [19:0]        ent_vpn_d [ENTRIES];
    logic [19:0]        ent_ppn_q [ENTRIES];
    logic [19:0]        ent_ppn_d [ENTRIES];
    logic [IdxW-1:0]    ptr_q, ptr_d;
    logic               fault_valid_q, fault_valid_d;
    logic [19:0]        fault_vpn_q, fault_vpn_d;
    logic [19:0]        walk_vpn_q, walk_vpn_d;

    logic        ic_valid_q, ic_valid_d;
    logic [29:0] ic_vpc_q, ic_vpc_d;
    logic [29:0] ic_ppc_q, ic_ppc_d;
    logic        ic_fault_q, ic_fault_d;
    logic [1:0]  ic_btype_q, ic_btype_d;
    logic [1:0]  ic_bm_pred_q, ic_bm_pred_d;
    logic [29:0] ic_target_q, ic_target_d;
    logic        ic_index_q, ic_index_d;
    logic        ic_hit_q, ic_hit_d;
    logic        ic_way_q, ic_way_d;

    logic [19:0]     lookup_vpn;
    logic            bare, hit, hit_x, hit_u, frec_hit, resolved, perm_fault;
    logic [19:0]     hit_ppn;
    logic [29:0]     xl_ppc;
    logic            xl_fault;
    logic            free_found;
    logic [IdxW-1:0] free_idx, victim;
    logic            load, start_walk, resp_take, fill_en, fault_wr;

    // Combinational lookup of the incoming PC against the ITLB and the fault record
    always_comb begin
        lookup_vpn = pcgen_pc_i[29:10];
        hit        = 1'b0;
        hit_ppn    = '0;
        hit_x      = 1'b0;
        hit_u      = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (ent_valid_q[i] && (ent_vpn_q[i] == lookup_vpn)) begin
                hit     = 1'b1;
                hit_ppn = ent_ppn_q[i];
                hit_x   = ent_x_q[i];
                hit_u   = ent_u_q[i];
            end
        end
        bare       = !satp_mode_i || (priv_i == 2'b11);
        frec_hit   = fault_valid_q && (fault_vpn_q == lookup_vpn);
        resolved   = bare || hit || frec_hit;
        perm_fault = !hit_x || ((priv_i == 2'b00) && !hit_u) || ((priv_i == 2'b01) && hit_u);
        if (bare) begin
            xl_ppc   = pcgen_pc_i;
            xl_fault = 1'b0;
        end else if (hit) begin
            xl_ppc   = {hit_ppn, pcgen_pc_i[9:0]};
            xl_fault = perm_fault;
        end else begin
            // Fault-record match: no translation exists, pass the VA along with the fault
            xl_ppc   = pcgen_pc_i;
            xl_fault = 1'b1;
        end
    end

    // Refill victim: lowest invalid entry, otherwise the round-robin pointer
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!ent_valid_q[i]) begin
                free_found = 1'b1;
                free_idx   = IdxW'(i);
            end
        end
        victim = free_found ? free_idx : ptr_q;
    end

    // State register
    always_ff @(posedge core_clock_i or negedge core_reset_n_i) begin
        if (!core_reset_n_i) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; an accepted walk request is always drained before returning to RUN
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun: begin
                if (!core_flush_i && pcgen_valid_i && !resolved) state_d = StWalkReq;
            end
            StWalkReq: begin
                if (ptw_req_ready_i)   state_d = core_flush_i ? StDrain : StWalkWait;
                else if (core_flush_i) state_d = StRun;
            end
            StWalkWait: begin
                if (ptw_resp_valid_i)  state_d = StRun;
                else if (core_flush_i) state_d = StDrain;
            end
            StDrain: begin
                if (ptw_resp_valid_i) state_d = StRun;
            end
            default: state_d = StRun;
        endcase
    end

    // FSM outputs
    always_comb begin
        pcgen_busy_o    = pcgen_valid_i && ((state_q != StRun) || !resolved || ic_busy_i);
        ptw_req_valid_o = (state_q == StWalkReq);
        ptw_req_vpn_o   = walk_vpn_q;
    end

    // Table, fault record and output-register next-state
    always_comb begin
        load       = (state_q == StRun) && pcgen_valid_i && resolved && !ic_busy_i &&
                     !core_flush_i;
        start_walk = (state_q == StRun) && pcgen_valid_i && !resolved && !core_flush_i;
        resp_take  = (state_q == StWalkWait) && ptw_resp_valid_i;
        fill_en    = resp_take && !ptw_resp_fault_i && !sfence_i;
        fault_wr   = resp_take && ptw_resp_fault_i && !sfence_i;

        ent_valid_d   = ent_valid_q;
        ent_x_d       = ent_x_q;
        ent_u_d       = ent_u_q;
        ent_vpn_d     = ent_vpn_q;
        ent_ppn_d     = ent_ppn_q;
        ptr_d         = ptr_q;
        fault_valid_d = fault_valid_q;
        fault_vpn_d   = fault_vpn_q;
        walk_vpn_d    = start_walk ? lookup_vpn : walk_vpn_q;

        if (fill_en) begin
            ent_valid_d[victim] = 1'b1;
            ent_vpn_d[victim]   = walk_vpn_q;
            ent_ppn_d[victim]   = ptw_resp_ppn_i;
            ent_x_d[victim]     = ptw_resp_x_i;
            ent_u_d[victim]     = ptw_resp_u_i;
            ptr_d               = ptr_q + IdxW'(1);
        end
        if (fault_wr) begin
            fault_valid_d = 1'b1;
            fault_vpn_d   = walk_vpn_q;
        end
        if (sfence_i) begin
            ent_valid_d   = '0;
            fault_valid_d = 1'b0;
        end

        ic_valid_d   = ic_valid_q;
        ic_vpc_d     = ic_vpc_q;
        ic_ppc_d     = ic_ppc_q;
        ic_fault_d   = ic_fault_q;
        ic_btype_d   = ic_btype_q;
        ic_bm_pred_d = ic_bm_pred_q;
        ic_target_d  = ic_target_q;
        ic_index_d   = ic_index_q;
        ic_hit_d     = ic_hit_q;
        ic_way_d     = ic_way_q;
        if (core_flush_i) begin
            ic_valid_d = 1'b0;
        end else if (load) begin
            ic_valid_d   = 1'b1;
            ic_vpc_d     = pcgen_pc_i;
            ic_ppc_d     = xl_ppc;
            ic_fault_d   = xl_fault;
            ic_btype_d   = pcgen_btype_i;
            ic_bm_pred_d = pcgen_bm_pred_i;
            ic_target_d  = pcgen_target_i;
            ic_index_d   = pcgen_index_i;
            ic_hit_d     = pcgen_hit_i;
            ic_way_d     = pcgen_way_i;
        end else if (!ic_busy_i) begin
            ic_valid_d = 1'b0;
        end
    end

    // Table, fault record, walk VPN and output registers
    always_ff @(posedge core_clock_i or negedge core_reset_n_i) begin
        if (!core_reset_n_i) begin
            ent_valid_q   <= '0;
            ent_x_q       <= '0;
            ent_u_q       <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ent_vpn_q[i] <= '0;
                ent_ppn_q[i] <= '0;
            end
            ptr_q         <= '0;
            fault_valid_q <= 1'b0;
            fault_vpn_q   <= '0;
            walk_vpn_q    <= '0;
            ic_valid_q    <= 1'b0;
            ic_vpc_q      <= '0;
            ic_ppc_q      <= '0;
            ic_fault_q    <= 1'b0;
            ic_btype_q    <= '0;
            ic_bm_pred_q  <= '0;
            ic_target_q   <= '0;
            ic_index_q    <= 1'b0;
            ic_hit_q      <= 1'b0;
            ic_way_q      <= 1'b0;
        end else begin
            ent_valid_q   <= ent_valid_d;
            ent_x_q       <= ent_x_d;
            ent_u_q       <= ent_u_d;
            ent_vpn_q     <= ent_vpn_d;
            ent_ppn_q     <= ent_ppn_d;
            ptr_q         <= ptr_d;
            fault_valid_q <= fault_valid_d;
            fault_vpn_q   <= fault_vpn_d;
            walk_vpn_q    <= walk_vpn_d;
            ic_valid_q    <= ic_valid_d;
            ic_vpc_q      <= ic_vpc_d;
            ic_ppc_q      <= ic_ppc_d;
            ic_fault_q    <= ic_fault_d;
            ic_btype_q    <= ic_btype_d;
            ic_bm_pred_q  <= ic_bm_pred_d;
            ic_target_q   <= ic_target_d;
            ic_index_q    <= ic_index_d;
            ic_hit_q      <= ic_hit_d;
            ic_way_q      <= ic_way_d;
        end
    end

    assign ic_valid_o   = ic_valid_q;
    assign ic_vpc_o     = ic_vpc_q;
    assign ic_ppc_o     = ic_ppc_q;
    assign ic_fault_o   = ic_fault_q;
    assign ic_btype_o   = ic_btype_q;
    assign ic_bm_pred_o = ic_bm_pred_q;
    assign ic_target_o  = ic_target_q;
    assign ic_index_o   = ic_index_q;
    assign ic_hit_o     = ic_hit_q;
    assign ic_way_o     = ic_way_q;

endmodule
